// File: rtl/segment_if_id.sv
// IF/ID pipeline register: captures fetch PC and instruction, exposes pre-sliced fields to decode.
// Latency 1 cycle; optional stall/flush ports under SEGMENT_IF_ID_STALL_FLUSH_EN.
module segment_if_id #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_out,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [1:0]  instr_31_30,
  output logic [4:0]  instr_29_25,
  output logic [3:0]  instr_27_24,
  output logic [3:0]  instr_21_18,
  output logic [3:0]  instr_20_17,
  output logic [3:0]  instr_7_4,
  output logic [3:0]  instr_23_20,
  output logic [3:0]  instr_16_13,
  output logic [3:0]  instr_25_22,
  output logic [3:0]  instr_24_21,
  output logic [3:0]  instr_11_8,
  output logic [27:0] instr_27_0
`ifdef SEGMENT_IF_ID_STALL_FLUSH_EN
  ,
  input  logic        stall,
  input  logic        flush
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

`ifdef SEGMENT_IF_ID_STALL_FLUSH_EN
  // Flush inserts a bubble and wins over stall.
  always_comb begin
    pc_d = pc_out;
    ir_d = instruction;
    if (flush) begin
      pc_d = RESET_PC;
      ir_d = RESET_INSTR;
    end else if (stall) begin
      pc_d = pc_q;
      ir_d = ir_q;
    end
  end
`else
  always_comb begin
    pc_d = pc_out;
    ir_d = instruction;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      ir_q <= RESET_INSTR;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  // Fields come from the held word only, so decode never sees a mid-cycle fetch change.
  assign pc          = pc_q;
  assign instr_31_30 = ir_q[31:30];
  assign instr_29_25 = ir_q[29:25];
  assign instr_27_24 = ir_q[27:24];
  assign instr_21_18 = ir_q[21:18];
  assign instr_20_17 = ir_q[20:17];
  assign instr_7_4   = ir_q[7:4];
  assign instr_23_20 = ir_q[23:20];
  assign instr_16_13 = ir_q[16:13];
  assign instr_25_22 = ir_q[25:22];
  assign instr_24_21 = ir_q[24:21];
  assign instr_11_8  = ir_q[11:8];
  assign instr_27_0  = ir_q[27:0];

endmodule

// File: tb/tb_segment_if_id.sv
// Randomized bench for segment_if_id against a field-extraction reference model.
module tb_segment_if_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [1:0]  instr_31_30;
  logic [4:0]  instr_29_25;
  logic [3:0]  instr_27_24, instr_21_18, instr_20_17, instr_7_4, instr_23_20;
  logic [3:0]  instr_16_13, instr_25_22, instr_24_21, instr_11_8;
  logic [27:0] instr_27_0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ir;

  segment_if_id dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .instruction(instruction), .pc(pc),
    .instr_31_30(instr_31_30), .instr_29_25(instr_29_25), .instr_27_24(instr_27_24),
    .instr_21_18(instr_21_18), .instr_20_17(instr_20_17), .instr_7_4(instr_7_4),
    .instr_23_20(instr_23_20), .instr_16_13(instr_16_13), .instr_25_22(instr_25_22),
    .instr_24_21(instr_24_21), .instr_11_8(instr_11_8), .instr_27_0(instr_27_0)
`ifdef SEGMENT_IF_ID_STALL_FLUSH_EN
    , .stall(stall), .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] fld(input int lo, input int w);
    return (exp_ir >> lo) & ((32'h1 << w) - 32'h1);
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".pc"},    pc,                     exp_pc);
    chk({ph, ".31_30"}, {30'b0, instr_31_30},   fld(30, 2));
    chk({ph, ".29_25"}, {27'b0, instr_29_25},   fld(25, 5));
    chk({ph, ".27_24"}, {28'b0, instr_27_24},   fld(24, 4));
    chk({ph, ".21_18"}, {28'b0, instr_21_18},   fld(18, 4));
    chk({ph, ".20_17"}, {28'b0, instr_20_17},   fld(17, 4));
    chk({ph, ".7_4"},   {28'b0, instr_7_4},     fld(4, 4));
    chk({ph, ".23_20"}, {28'b0, instr_23_20},   fld(20, 4));
    chk({ph, ".16_13"}, {28'b0, instr_16_13},   fld(13, 4));
    chk({ph, ".25_22"}, {28'b0, instr_25_22},   fld(22, 4));
    chk({ph, ".24_21"}, {28'b0, instr_24_21},   fld(21, 4));
    chk({ph, ".11_8"},  {28'b0, instr_11_8},    fld(8, 4));
    chk({ph, ".27_0"},  {4'b0, instr_27_0},     fld(0, 28));
  endtask

  // One pipeline cycle: present inputs, take the edge, then optionally
  // wiggle inputs mid-cycle and/or pulse async reset before the next edge.
  task automatic step(input logic [31:0] pcv, input logic [31:0] insv,
                      input bit stl, input bit fls, input bit glitch, input bit do_rst);
    pc_out      = pcv;
    instruction = insv;
    stall       = stl;
    flush       = fls;
    @(posedge clk);
`ifdef SEGMENT_IF_ID_STALL_FLUSH_EN
    if (fls) begin
      exp_pc = 32'h0;
      exp_ir = 32'h0;
    end else if (!stl) begin
      exp_pc = pcv;
      exp_ir = insv;
    end
`else
    exp_pc = pcv;
    exp_ir = insv;
`endif
    #1 check_all("cap");
    if (glitch) begin
      #1;
      pc_out      = $urandom;
      instruction = $urandom;
      #1 check_all("hold");
    end
    if (do_rst) begin
      #1 rst = 1'b0;
      exp_pc = 32'h0;
      exp_ir = 32'h0;
      #1 check_all("arst");
      rst = 1'b1;
    end
  endtask

  initial begin
    rst         = 1'b0;
    pc_out      = 32'hDEAD_BEEF;
    instruction = 32'h1234_5678;
    exp_pc      = 32'h0;
    exp_ir      = 32'h0;
    #2 check_all("rst0");
    pc_out      = $urandom;
    instruction = $urandom;
    #1 check_all("rst1");
    @(posedge clk);
    #1 check_all("rst_edge");
    rst = 1'b1;

    // Directed vectors: captures, mid-cycle hold, back-to-back, async reset.
    step(32'd1, 32'hAFAF_AFAF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd2, 32'hF00F_00FC, 1'b0, 1'b0, 1'b1, 1'b0);
    step(32'd3, 32'hFF0F_F0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd4, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd5, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'd6, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'd7, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'd8, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'd9, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step($urandom, $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
